// File: rtl/write_buffer_if.sv
// Processor and bus signal bundle for the posted write buffer.
// master: requester/bus-slave side; slave: the write buffer itself.
interface write_buffer_if;
  logic        WriteData;
  logic        ReadData;
  logic [15:0] DataAddr;
  logic [15:0] DataOut;
  logic [15:0] DataIn;
  logic        DataDone;
  logic        BusRead;
  logic        BusWrite;
  logic [15:0] BusAddr;
  logic [15:0] BusWrData;
  logic [15:0] BusRdData;
  logic        BusDone;
  logic        Full;
  logic        Empty;

  modport master (
    output WriteData, ReadData, DataAddr, DataOut,
    output BusRdData, BusDone,
    input  DataIn, DataDone,
    input  BusRead, BusWrite, BusAddr, BusWrData,
    input  Full, Empty
  );

  modport slave (
    input  WriteData, ReadData, DataAddr, DataOut,
    input  BusRdData, BusDone,
    output DataIn, DataDone,
    output BusRead, BusWrite, BusAddr, BusWrData,
    output Full, Empty
  );
endinterface

// File: rtl/write_buffer.sv
// Posted write buffer: FIFO of DEPTH writes drained to the bus in order,
// reads forwarded from the youngest buffered match, misses wait for drain.
module write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  write_buffer_if.slave io
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [15:0] addr_mem [DEPTH];
  logic [15:0] data_mem [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic          wr_req;
  logic          rd_req;
  logic          enq;
  logic          deq;
  logic          fwd;
  logic          rd_done;
  logic          hit;
  logic [15:0]   hit_data;
  logic [AW-1:0] slot;

  logic          bus_wr_nxt;
  logic          bus_rd_nxt;
  logic [15:0]   bus_addr_nxt;
  logic [15:0]   bus_wdata_nxt;

  // A request seen while DataDone is high has just been served.
  assign wr_req = io.WriteData && !io.DataDone;
  assign rd_req = io.ReadData && !io.WriteData && !io.DataDone;
  assign enq    = wr_req && (count < DEPTH_C);
  assign fwd    = rd_req && hit;

  // Oldest to youngest scan; the last match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    slot     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + AW'(k);
      if (((AW+1)'(k) < count) &&
          (addr_mem[slot] == io.DataAddr)) begin
        hit      = 1'b1;
        hit_data = data_mem[slot];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    bus_wr_nxt    = io.BusWrite;
    bus_rd_nxt    = io.BusRead;
    bus_addr_nxt  = io.BusAddr;
    bus_wdata_nxt = io.BusWrData;
    deq           = 1'b0;
    rd_done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          state_nxt     = WR;
          bus_wr_nxt    = 1'b1;
          bus_addr_nxt  = addr_mem[rd_ptr];
          bus_wdata_nxt = data_mem[rd_ptr];
        end else if (rd_req) begin
          // empty FIFO means no forwarding hit is possible
          state_nxt    = RD;
          bus_rd_nxt   = 1'b1;
          bus_addr_nxt = io.DataAddr;
        end
      end
      WR: begin
        if (io.BusDone) begin
          state_nxt  = IDLE;
          bus_wr_nxt = 1'b0;
          deq        = 1'b1;
        end
      end
      RD: begin
        if (io.BusDone) begin
          state_nxt  = IDLE;
          bus_rd_nxt = 1'b0;
          rd_done    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      io.DataDone  <= 1'b0;
      io.DataIn    <= '0;
      io.BusRead   <= 1'b0;
      io.BusWrite  <= 1'b0;
      io.BusAddr   <= '0;
      io.BusWrData <= '0;
      io.Full      <= 1'b0;
      io.Empty     <= 1'b1;
    end else begin
      state        <= state_nxt;
      io.BusRead   <= bus_rd_nxt;
      io.BusWrite  <= bus_wr_nxt;
      io.BusAddr   <= bus_addr_nxt;
      io.BusWrData <= bus_wdata_nxt;
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(enq) - (AW+1)'(deq);
      io.DataDone <= enq || fwd || rd_done;
      if (fwd) begin
        io.DataIn <= hit_data;
      end else if (rd_done) begin
        io.DataIn <= io.BusRdData;
      end
      // flags follow count one cycle later
      io.Full  <= (count == DEPTH_C);
      io.Empty <= (count == '0);
    end
  end

  always_ff @(posedge Clock) begin
    if (enq) begin
      addr_mem[wr_ptr] <= io.DataAddr;
      data_mem[wr_ptr] <= io.DataOut;
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// Scoreboard bench for write_buffer: directed scenarios plus random
// traffic checked against a memory-coherence reference model.
module tb_write_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic        rd;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  write_buffer_if io ();

  write_buffer #(.DEPTH(DEPTH)) dut (
    .Clock (clk),
    .Reset (rst),
    .io    (io.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  exp_t        exp_cpu [$];
  logic [31:0] exp_bw [$];
  logic [15:0] model_mem [logic [15:0]];
  logic [15:0] bus_mem [logic [15:0]];

  logic        stall = 1'b0;
  int          allow = 0;
  logic        rd_pend = 1'b0;
  logic [15:0] rd_addr = '0;
  int          bw_starts = 0;
  int          br_starts = 0;
  logic        fifth_done = 1'b0;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0030) ? 16'h5A5A : (a ^ 16'hC3A5);
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Processor request; holds until DataDone, returns negedges waited.
  task automatic cpu_req(input logic wr, input logic rd,
                         input logic [15:0] a, input logic [15:0] d,
                         output int lat);
    exp_t e;
    @(posedge clk); #1;
    io.WriteData = wr;
    io.ReadData  = rd;
    io.DataAddr  = a;
    io.DataOut   = d;
    if (wr) begin
      model_mem[a] = d;
      exp_bw.push_back({a, d});
      e.rd   = 1'b0;
      e.data = d;
    end else begin
      e.rd    = 1'b1;
      e.data  = model_mem.exists(a) ? model_mem[a] : init_val(a);
      rd_addr = a;
      rd_pend = 1'b1;
    end
    exp_cpu.push_back(e);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!io.DataDone && lat < 200);
    if (!io.DataDone) chk("cpu_timeout", 32'(lat), 32'(0));
    @(posedge clk); #1;
    io.WriteData = 1'b0;
    io.ReadData  = 1'b0;
    rd_pend      = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(io.Empty && !io.BusWrite && !io.BusRead &&
             exp_bw.size() == 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(io.Empty && exp_bw.size() == 0), 32'(1));
  endtask

  // Bus slave: random latency, honours stall with one-shot grants.
  initial begin : responder
    int lat;
    lat = 0;
    forever begin
      @(posedge clk); #2;
      if (io.BusDone) begin
        io.BusDone = 1'b0;
      end else if ((io.BusWrite || io.BusRead) && (!stall || allow > 0)) begin
        if (lat > 0) begin
          lat--;
        end else begin
          if (allow > 0) allow--;
          if (io.BusWrite) begin
            bus_mem[io.BusAddr] = io.BusWrData;
          end else begin
            io.BusRdData = bus_mem.exists(io.BusAddr) ?
                           bus_mem[io.BusAddr] : init_val(io.BusAddr);
          end
          io.BusDone = 1'b1;
          lat = $urandom_range(0, 3);
        end
      end
    end
  end

  // Monitor: pops expectations as the DUT presents results.
  initial begin : monitor
    int          occ;
    int          occ_d;
    logic        deq_prev;
    logic        enq;
    logic        prev_bw;
    logic        prev_br;
    logic        prev_done;
    logic [15:0] prev_addr;
    logic [15:0] prev_wd;
    logic [15:0] exp_din;
    logic [31:0] w;
    exp_t        e;
    occ = 0; occ_d = 0; deq_prev = 0;
    prev_bw = 0; prev_br = 0; prev_done = 0;
    prev_addr = '0; prev_wd = '0; exp_din = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_bw.delete();
        occ = 0; occ_d = 0; deq_prev = 0;
        prev_bw = 0; prev_br = 0; prev_done = 0;
        exp_din = '0;
      end else begin
        enq = 1'b0;
        if (io.DataDone) begin
          if (exp_cpu.size() == 0) begin
            chk("done_unexpected", 32'(1), 32'(0));
          end else begin
            e = exp_cpu.pop_front();
            if (e.rd) exp_din = e.data;
            else enq = 1'b1;
          end
        end
        chk("data_in", 32'(io.DataIn), 32'(exp_din));
        occ = occ + int'(enq) - int'(deq_prev);
        chk("empty", 32'(io.Empty), 32'(occ_d == 0));
        chk("full", 32'(io.Full), 32'(occ_d == DEPTH));
        occ_d = occ;
        deq_prev = io.BusDone && io.BusWrite;
        if (io.BusWrite && io.BusRead) chk("both_strobes", 32'(1), 32'(0));
        if (prev_done && (io.BusWrite || io.BusRead))
          chk("strobe_drop", 32'(1), 32'(0));
        if (io.BusWrite && !prev_bw) begin
          bw_starts++;
          if (exp_bw.size() == 0) begin
            chk("bus_wr_unexpected", {io.BusAddr, io.BusWrData}, 32'(0));
          end else begin
            w = exp_bw.pop_front();
            chk("bus_wr", {io.BusAddr, io.BusWrData}, w);
          end
        end
        if (io.BusRead && !prev_br) begin
          br_starts++;
          chk("bus_rd_order", 32'(exp_bw.size() == 0 && rd_pend), 32'(1));
          chk("bus_rd_addr", 32'(io.BusAddr), 32'(rd_addr));
        end
        if ((io.BusWrite && prev_bw) || (io.BusRead && prev_br)) begin
          if (!prev_done)
            chk("bus_stable", {io.BusAddr, io.BusWrData},
                {prev_addr, prev_wd});
        end
        prev_bw   = io.BusWrite;
        prev_br   = io.BusRead;
        prev_done = io.BusDone;
        prev_addr = io.BusAddr;
        prev_wd   = io.BusWrData;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat;
    int n;
    int br0;
    int bw0;
    int r;
    io.WriteData = 1'b0;
    io.ReadData  = 1'b0;
    io.DataAddr  = '0;
    io.DataOut   = '0;
    io.BusRdData = '0;
    io.BusDone   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_done", 32'(io.DataDone), 32'(0));
    chk("rst_din", 32'(io.DataIn), 32'(0));
    chk("rst_bus", {14'd0, io.BusRead, io.BusWrite, io.BusAddr},
        32'(0));
    chk("rst_wdata", 32'(io.BusWrData), 32'(0));
    chk("rst_flags", {30'd0, io.Full, io.Empty}, 32'(1));

    // single write, idle bus
    cpu_req(1'b1, 1'b0, 16'h0010, 16'hBEEF, lat);
    chk("wr_latency", 32'(lat), 32'(2));
    @(negedge clk);
    chk("wr_bus_t2", {15'd0, io.BusWrite, io.BusAddr},
        {15'd0, 1'b1, 16'h0010});
    chk("wr_bus_data", 32'(io.BusWrData), 32'(16'hBEEF));
    wait_idle();

    // full FIFO stalls the fifth write
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_req(1'b1, 1'b0, 16'h0050 + 16'(i), 16'h1000 + 16'(i), lat);
      chk("fill_latency", 32'(lat), 32'(2));
    end
    fifth_done = 1'b0;
    fork
      begin
        int l5;
        cpu_req(1'b1, 1'b0, 16'h0054, 16'h5555, l5);
        fifth_done = 1'b1;
      end
    join_none
    repeat (8) @(negedge clk);
    chk("full_stall", 32'(fifth_done), 32'(0));
    chk("full_flag", 32'(io.Full), 32'(1));
    allow = 1;
    n = 0;
    while (!fifth_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("fifth_accept", 32'(fifth_done), 32'(1));
    stall = 1'b0;
    wait_idle();

    // forwarding picks the youngest entry
    stall = 1'b1;
    br0 = br_starts;
    cpu_req(1'b1, 1'b0, 16'h0020, 16'h1111, lat);
    cpu_req(1'b1, 1'b0, 16'h0020, 16'h2222, lat);
    cpu_req(1'b0, 1'b1, 16'h0020, 16'h0000, lat);
    chk("fwd_latency", 32'(lat), 32'(2));
    chk("fwd_data", 32'(io.DataIn), 32'(16'h2222));
    chk("fwd_no_busrd", 32'(br_starts), 32'(br0));
    stall = 1'b0;
    wait_idle();

    // read miss waits for drain then goes to the bus
    stall = 1'b1;
    br0 = br_starts;
    cpu_req(1'b1, 1'b0, 16'h0031, 16'hAAAA, lat);
    cpu_req(1'b1, 1'b0, 16'h0032, 16'hBBBB, lat);
    stall = 1'b0;
    cpu_req(1'b0, 1'b1, 16'h0030, 16'h0000, lat);
    chk("miss_data", 32'(io.DataIn), 32'(16'h5A5A));
    chk("miss_busrd", 32'(br_starts), 32'(br0 + 1));
    wait_idle();

    // write and read together is a write
    br0 = br_starts;
    cpu_req(1'b1, 1'b1, 16'h0040, 16'h0007, lat);
    chk("wr_rd_latency", 32'(lat), 32'(2));
    wait_idle();
    chk("wr_rd_no_busrd", 32'(br_starts), 32'(br0));

    // all-ones address drains like any other
    cpu_req(1'b1, 1'b0, 16'hFFFF, 16'h3C3C, lat);
    wait_idle();

    // reset during WR discards buffered writes
    stall = 1'b1;
    cpu_req(1'b1, 1'b0, 16'h0200, 16'h0A0A, lat);
    cpu_req(1'b1, 1'b0, 16'h0201, 16'h0B0B, lat);
    cpu_req(1'b1, 1'b0, 16'h0202, 16'h0C0C, lat);
    @(negedge clk);
    chk("pre_rst_wr", 32'(io.BusWrite), 32'(1));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_wr", {29'd0, io.BusWrite, io.Empty, io.DataDone},
        32'(3'b010));
    stall = 1'b0;
    bw0 = bw_starts;
    repeat (10) @(negedge clk);
    chk("rst_no_drain", 32'(bw_starts), 32'(bw0));

    // random traffic
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)
        cpu_req(1'b1, 1'b0, 16'h0100 + 16'($urandom_range(0, 7)),
                16'($urandom), lat);
      else if (r < 65)
        cpu_req(1'b1, 1'b1, 16'h0100 + 16'($urandom_range(0, 7)),
                16'($urandom), lat);
      else
        cpu_req(1'b0, 1'b1, 16'h0100 + 16'($urandom_range(0, 9)),
                16'h0000, lat);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("cpu_queue_empty", 32'(exp_cpu.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, named Clock and Reset.
REQ-002 Parameter DEPTH SHALL be declared: default 4, the number of posted-write entries (power of two, 2..16).
REQ-003 Clock  in  1  system clock; all state SHALL update on posedge Clock.
REQ-004 Reset  in  1  synchronous active-high reset.
REQ-005 WriteData  in  1  processor write request, held until DataDone.
REQ-006 ReadData  in  1  processor read request, held until DataDone.
REQ-007 DataAddr  in  16  processor request address.
REQ-008 DataOut  in  16  processor write data.
REQ-009 DataIn  out  16  read data returned to the processor.
REQ-010 DataDone  out  1  single-cycle completion pulse to the processor.
REQ-011 BusRead, BusWrite  out  1 each  bus request strobes, held until BusDone.
REQ-012 BusAddr, BusWrData  out  16 each  bus address and write data.
REQ-013 BusRdData  in  16  bus read data, valid when BusDone=1.
REQ-014 BusDone  in  1  bus completion, one cycle.
REQ-015 Full, Empty  out  1 each  FIFO status, registered.

Function
REQ-016 The processor request SHALL be sampled every cycle except a cycle in which DataDone=1; a request present while DataDone=1 SHALL be treated as already served.
REQ-017 WriteData and ReadData both high SHALL be handled as a write; the read is ignored.
REQ-018 Write accept: WriteData=1 and count<DEPTH SHALL enqueue {DataAddr, DataOut} and pulse DataDone the next cycle (latency 1).
REQ-019 Write while count==DEPTH SHALL stall with no DataDone until count<DEPTH at a sampling edge; an entry retiring in the same cycle SHALL NOT free a slot until the next cycle.
REQ-020 Read forwarding: ReadData=1 with DataAddr matching any buffered entry SHALL return the youngest matching entry's data on DataIn with DataDone the next cycle and no bus access.
REQ-021 Read miss: the read SHALL wait until the FIFO is empty and the bus FSM is IDLE, then issue to the bus.
REQ-022 The bus FSM SHALL have states IDLE, WR and RD.
REQ-023 IDLE->WR when the FIFO is non-empty: BusWrite=1, BusAddr/BusWrData = head entry.
REQ-024 WR->IDLE on BusDone: the head is dequeued in that cycle.
REQ-025 IDLE->RD when a pending read miss exists and the FIFO is empty: BusRead=1, BusAddr=DataAddr.
REQ-026 RD->IDLE on BusDone: BusRdData is captured into DataIn and DataDone pulses the next cycle.
REQ-027 Pending writes SHALL take priority over read misses; bus order SHALL equal processor write order.
REQ-028 Bus strobes and address/data SHALL remain stable from assertion until the BusDone cycle inclusive, and deassert the cycle after.
REQ-029 Enqueue and dequeue in the same cycle SHALL leave count unchanged.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 Full SHALL equal (count==DEPTH) and Empty SHALL equal (count==0), both updated one cycle after the count change.
REQ-032 DataIn SHALL hold its last value between reads.
REQ-033 Address 16'hFFFF SHALL be buffered and drained like any other write.

Reset
REQ-034 In a cycle with Reset=1, the FIFO SHALL be emptied, FSM->IDLE and pending requests dropped.
REQ-035 Reset values SHALL be DataDone=0, DataIn=0, BusRead=0, BusWrite=0, BusAddr=0, BusWrData=0, Full=0, Empty=1.
REQ-036 Reset during WR or RD SHALL drop the bus strobe the next cycle; buffered writes are discarded, not drained.
REQ-037 In the first cycle after Reset deasserts, requests SHALL be sampled normally.

Verification
REQ-038 Write 0x0010<=0xBEEF with an idle bus -> DataDone at T+1; BusWrite, BusAddr=0x0010, BusWrData=0xBEEF from T+2; Empty=1 after BusDone.
REQ-039 Bus stalled (BusDone=0), DEPTH=4: 5 writes -> 4 DataDone pulses, Full=1, 5th stalls; one BusDone -> 5th accepted, 5 bus writes in order.
REQ-040 Write 0x0020<=0x1111 then 0x0020<=0x2222 with the bus stalled, then read 0x0020 -> DataIn=0x2222, DataDone one cycle after the read, no BusRead.
REQ-041 Two buffered writes, then read 0x0030 (miss) -> both bus writes complete first; then BusRead with BusAddr=0x0030; BusRdData=0x5A5A with BusDone -> DataIn=0x5A5A, DataDone the next cycle.
REQ-042 Reset asserted mid-WR with 3 entries buffered -> BusWrite=0 the next cycle, Empty=1, DataDone=0, no further bus writes.
REQ-043 WriteData=ReadData=1 at 0x0040, data 0x0007 -> handled as a write only: 0x0040<=0x0007 enqueued, no BusRead.
